// File: rtl/riscv_multicycle_core.sv
// Multi-cycle RV subset core: one FSM walks fetch/decode/execute/memory/writeback over a
// single shared ALU, with instruction and data memories behind req/ready handshakes.
module riscv_multicycle_core #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] PC_RESET = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            retire,
    output logic [XLEN-1:0] pc_out,
    output logic            halted,
    output logic            fault
);

    localparam logic [6:0]  OPC_R   = 7'b0110011;
    localparam logic [6:0]  OPC_I   = 7'b0010011;
    localparam logic [6:0]  OPC_LD  = 7'b0000011;
    localparam logic [6:0]  OPC_SD  = 7'b0100011;
    localparam logic [6:0]  OPC_BR  = 7'b1100011;
    localparam logic [31:0] EBREAK  = 32'h0010_0073;
    localparam logic [2:0]  LSU_F3  = (XLEN == 64) ? 3'b011 : 3'b010;
    localparam int          ALIGN_W = (XLEN == 64) ? 3 : 2;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
    typedef enum logic [2:0] {OP_ALU, OP_ADDI, OP_LD, OP_SD, OP_BR, OP_EBREAK, OP_ILLEGAL} op_t;
    typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR} alu_t;

    state_t                 state, state_nxt;
    logic [XLEN-1:0]        pc;
    logic [XLEN-1:0]        pc_plus4;
    logic [31:0]            ir_p0;
    logic signed [XLEN-1:0] a_p1, b_p1, imm_p1;
    logic signed [XLEN-1:0] r_p2;
    logic signed [XLEN-1:0] mdr_p3;
    logic                   fault_q;
    logic signed [XLEN-1:0] rf [0:31];

    op_t                    cls;
    logic [2:0]             funct3;
    logic [4:0]             rs1, rs2, rd;
    alu_t                   alu_op;
    logic signed [XLEN-1:0] alu_a, alu_b, alu_out;
    logic                   br_taken, mem_op, misaligned;

    function automatic op_t decode_op(input logic [31:0] ir);
        op_t        op;
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = ir[14:12];
        f7 = ir[31:25];
        op = OP_ILLEGAL;
        case (ir[6:0])
            OPC_R: begin
                if ((f7 == 7'b0000000 && (f3 == 3'b000 || f3 == 3'b110 || f3 == 3'b111)) ||
                    (f7 == 7'b0100000 && f3 == 3'b000))
                    op = OP_ALU;
            end
            OPC_I:  if (f3 == 3'b000) op = OP_ADDI;
            OPC_LD: if (f3 == LSU_F3) op = OP_LD;
            OPC_SD: if (f3 == LSU_F3) op = OP_SD;
            OPC_BR: begin
                if (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b100 || f3 == 3'b101)
                    op = OP_BR;
            end
            default: begin
                if (ir == EBREAK) op = OP_EBREAK;
            end
        endcase
        return op;
    endfunction

    // B-type keeps bit 0 as zero so the target is PC + imm with no extra shift.
    function automatic logic signed [XLEN-1:0] build_imm(input logic [31:0] ir);
        logic [12:0] raw;
        case (ir[6:0])
            OPC_I, OPC_LD: raw = {ir[31], ir[31:20]};
            OPC_SD:        raw = {ir[31], ir[31:25], ir[11:7]};
            OPC_BR:        raw = {ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            default:       raw = '0;
        endcase
        return $signed({{(XLEN-13){raw[12]}}, raw});
    endfunction

    function automatic logic signed [XLEN-1:0] alu_calc(input alu_t op,
                                                        input logic signed [XLEN-1:0] a,
                                                        input logic signed [XLEN-1:0] b);
        case (op)
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            default: return a + b;
        endcase
    endfunction

    assign cls      = decode_op(ir_p0);
    assign funct3   = ir_p0[14:12];
    assign rs1      = ir_p0[19:15];
    assign rs2      = ir_p0[24:20];
    assign rd       = ir_p0[11:7];
    assign pc_plus4 = pc + XLEN'(4);
    assign mem_op   = (cls == OP_LD) || (cls == OP_SD);

    always_comb begin
        alu_a  = a_p1;
        alu_b  = imm_p1;
        alu_op = ALU_ADD;
        case (cls)
            OP_ALU: begin
                alu_b = b_p1;
                case (funct3)
                    3'b111:  alu_op = ALU_AND;
                    3'b110:  alu_op = ALU_OR;
                    default: alu_op = ir_p0[30] ? ALU_SUB : ALU_ADD;
                endcase
            end
            OP_BR:   alu_a = $signed(pc);
            default: ;
        endcase
        alu_out = alu_calc(alu_op, alu_a, alu_b);
    end

    always_comb begin
        case (funct3)
            3'b000:  br_taken = (a_p1 == b_p1);
            3'b001:  br_taken = (a_p1 != b_p1);
            3'b100:  br_taken = (a_p1 < b_p1);
            3'b101:  br_taken = (a_p1 >= b_p1);
            default: br_taken = 1'b0;
        endcase
    end

    assign misaligned = (alu_out[ALIGN_W-1:0] != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:  if (imem_ready) state_nxt = S_DECODE;
            S_DECODE: state_nxt = (cls == OP_ILLEGAL || cls == OP_EBREAK) ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (cls == OP_BR)  state_nxt = S_FETCH;
                else if (mem_op)   state_nxt = misaligned ? S_HALT : S_MEM;
                else               state_nxt = S_WB;
            end
            S_MEM:    if (dmem_ready) state_nxt = (cls == OP_SD) ? S_FETCH : S_WB;
            S_WB:     state_nxt = S_FETCH;
            default:  state_nxt = S_HALT;
        endcase
    end

    // Requests are masked by reset so an outstanding access drops the instant reset rises.
    always_comb begin
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        retire     = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: imem_req = 1'b1;
                S_EXEC:  retire   = (cls == OP_BR);
                S_MEM: begin
                    dmem_req   = 1'b1;
                    dmem_we    = (cls == OP_SD);
                    dmem_addr  = r_p2;
                    dmem_wdata = b_p1;
                    retire     = (cls == OP_SD) && dmem_ready;
                end
                S_WB:    retire = 1'b1;
                default: ;
            endcase
        end
    end

    assign imem_addr = pc;
    assign pc_out    = pc;
    assign halted    = (state == S_HALT);
    assign fault     = fault_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc      <= PC_RESET;
            ir_p0   <= '0;
            a_p1    <= '0;
            b_p1    <= '0;
            imm_p1  <= '0;
            r_p2    <= '0;
            mdr_p3  <= '0;
            fault_q <= 1'b0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            if ((state == S_DECODE && cls == OP_ILLEGAL) ||
                (state == S_EXEC && mem_op && misaligned))
                fault_q <= 1'b1;
            case (state)
                // fetch -> decode
                S_FETCH: if (imem_ready) ir_p0 <= imem_rdata;
                // decode -> execute
                S_DECODE: begin
                    a_p1   <= (rs1 == 5'd0) ? '0 : rf[rs1];
                    b_p1   <= (rs2 == 5'd0) ? '0 : rf[rs2];
                    imm_p1 <= build_imm(ir_p0);
                end
                // execute -> memory / writeback
                S_EXEC: begin
                    r_p2 <= alu_out;
                    if (cls == OP_BR) pc <= br_taken ? alu_out : pc_plus4;
                end
                // memory -> writeback
                S_MEM: begin
                    if (dmem_ready) begin
                        if (cls == OP_SD) pc <= pc_plus4;
                        else              mdr_p3 <= dmem_rdata;
                    end
                end
                S_WB: begin
                    if (rd != 5'd0) rf[rd] <= (cls == OP_LD) ? mdr_p3 : r_p2;
                    pc <= pc_plus4;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_multicycle_core.sv
// Directed bench for riscv_multicycle_core: an RV64 core with a wait-state data memory
// and an RV32 core with zero-wait memories, both driven from hand-written programs.
module tb_riscv_multicycle_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rst32 = 1'b1;
    always #5 clk = ~clk;

    logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, retire, halted, fault;
    logic [31:0] imem_rdata;
    logic [63:0] imem_addr, dmem_addr, dmem_wdata, dmem_rdata, pc_out;

    logic        imem_req32, imem_ready32, dmem_req32, dmem_we32, dmem_ready32;
    logic        retire32, halted32, fault32;
    logic [31:0] imem_rdata32, imem_addr32, dmem_addr32, dmem_wdata32, dmem_rdata32, pc_out32;

    logic [31:0] imem   [0:63];
    logic [31:0] imem32 [0:63];
    logic [63:0] dmem   [0:31];
    logic [63:0] st_addr [0:63];
    logic [63:0] st_data [0:63];
    int          st_cnt = 0;
    int          dreq_cycles = 0;
    int          dcnt = 0;
    int          dmem_wait = 0;
    logic [31:0] st32_addr = '0;
    logic [31:0] st32_data = '0;
    int          st32_cnt = 0;

    int vectors = 0;
    int miscompares = 0;

    riscv_multicycle_core #(.XLEN(64), .PC_RESET(64'h0)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .retire(retire), .pc_out(pc_out), .halted(halted), .fault(fault)
    );

    riscv_multicycle_core #(.XLEN(32), .PC_RESET(32'h0)) dut32 (
        .clk(clk), .reset(rst32),
        .imem_req(imem_req32), .imem_addr(imem_addr32), .imem_ready(imem_ready32), .imem_rdata(imem_rdata32),
        .dmem_req(dmem_req32), .dmem_we(dmem_we32), .dmem_addr(dmem_addr32), .dmem_wdata(dmem_wdata32),
        .dmem_ready(dmem_ready32), .dmem_rdata(dmem_rdata32),
        .retire(retire32), .pc_out(pc_out32), .halted(halted32), .fault(fault32)
    );

    assign imem_ready   = imem_req;
    assign imem_rdata   = imem[imem_addr[7:2]];
    assign dmem_ready   = dmem_req && (dcnt >= dmem_wait);
    assign dmem_rdata   = dmem[dmem_addr[7:3]];
    assign imem_ready32 = imem_req32;
    assign imem_rdata32 = imem32[imem_addr32[7:2]];
    assign dmem_ready32 = dmem_req32;
    assign dmem_rdata32 = 32'h0;

    always @(posedge clk) begin
        if (dmem_req) begin
            dreq_cycles <= dreq_cycles + 1;
            if (dmem_ready) begin
                dcnt <= 0;
                if (dmem_we) begin
                    dmem[dmem_addr[7:3]]  <= dmem_wdata;
                    st_addr[st_cnt[5:0]]  <= dmem_addr;
                    st_data[st_cnt[5:0]]  <= dmem_wdata;
                    st_cnt                <= st_cnt + 1;
                end
            end else begin
                dcnt <= dcnt + 1;
            end
        end else begin
            dcnt <= 0;
        end
    end

    always @(posedge clk) begin
        if (dmem_req32 && dmem_we32) begin
            st32_addr <= dmem_addr32;
            st32_data <= dmem_wdata32;
            st32_cnt  <= st32_cnt + 1;
        end
    end

    function automatic logic [31:0] ADDI(input int rd, input int rs1, input int imm);
        return {imm[11:0], rs1[4:0], 3'b000, rd[4:0], 7'b0010011};
    endfunction
    function automatic logic [31:0] RTYPE(input logic [6:0] f7, input logic [2:0] f3,
                                          input int rd, input int rs1, input int rs2);
        return {f7, rs2[4:0], rs1[4:0], f3, rd[4:0], 7'b0110011};
    endfunction
    function automatic logic [31:0] LOAD(input logic [2:0] f3, input int rd, input int rs1, input int imm);
        return {imm[11:0], rs1[4:0], f3, rd[4:0], 7'b0000011};
    endfunction
    function automatic logic [31:0] STORE(input logic [2:0] f3, input int rs2, input int rs1, input int imm);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] BR(input logic [2:0] f3, input int rs1, input int rs2, input int imm);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    localparam logic [31:0] EBRK = 32'h0010_0073;

    task automatic enter_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    // Leaves the bench inside the cycle in which the n-th retire pulse is seen.
    task automatic run_retires(input int n, input int limit, output int cycles);
        int rc;
        rc = 0;
        cycles = 0;
        while (cycles < limit) begin
            cycles++;
            if (retire) rc++;
            if (rc == n) break;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic run_halt(input int limit, output int cycles);
        cycles = 0;
        while (!halted && cycles < limit) begin
            @(negedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_imem_req: got %b want 0", imem_req); end
        vectors++; if (dmem_req !== 1'b0) begin miscompares++; $display("FAIL reset_dmem_req: got %b want 0", dmem_req); end
        vectors++; if (dmem_we !== 1'b0) begin miscompares++; $display("FAIL reset_dmem_we: got %b want 0", dmem_we); end
        vectors++; if (retire !== 1'b0) begin miscompares++; $display("FAIL reset_retire: got %b want 0", retire); end
        vectors++; if (halted !== 1'b0 || fault !== 1'b0) begin miscompares++; $display("FAIL reset_halt_fault: got %b%b want 00", halted, fault); end
        vectors++; if (pc_out !== 64'h0 || imem_addr !== 64'h0) begin miscompares++; $display("FAIL reset_pc: got %h/%h want 0", pc_out, imem_addr); end
        vectors++; if (dmem_addr !== 64'h0 || dmem_wdata !== 64'h0) begin miscompares++; $display("FAIL reset_dmem_bus: got %h/%h want 0", dmem_addr, dmem_wdata); end
        vectors++; if (imem_req32 !== 1'b0 || pc_out32 !== 32'h0) begin miscompares++; $display("FAIL reset32: got req %b pc %h want 0/0", imem_req32, pc_out32); end
    endtask

    task automatic test_alu();
        int cyc, s0;
        enter_reset();
        imem[0]  = ADDI(1, 0, 5);
        imem[1]  = ADDI(2, 0, -3);
        imem[2]  = RTYPE(7'b0000000, 3'b000, 3, 1, 2);
        imem[3]  = RTYPE(7'b0100000, 3'b000, 4, 2, 1);
        imem[4]  = ADDI(8, 0, 12);
        imem[5]  = RTYPE(7'b0000000, 3'b111, 6, 1, 8);
        imem[6]  = RTYPE(7'b0000000, 3'b110, 7, 1, 8);
        imem[7]  = ADDI(0, 0, 7);
        imem[8]  = STORE(3'b011, 3, 0, 0);
        imem[9]  = STORE(3'b011, 4, 0, 8);
        imem[10] = STORE(3'b011, 6, 0, 16);
        imem[11] = STORE(3'b011, 7, 0, 24);
        imem[12] = STORE(3'b011, 0, 0, 32);
        imem[13] = EBRK;
        dmem_wait = 0;
        s0 = st_cnt;
        release_reset();
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin miscompares++; $display("FAIL first_fetch: got req %b addr %h want 1/0", imem_req, imem_addr); end
        run_retires(3, 40, cyc);
        vectors++; if (cyc !== 12) begin miscompares++; $display("FAIL alu_3instr_cycles: got %0d want 12", cyc); end
        run_halt(200, cyc);
        vectors++; if (halted !== 1'b1 || fault !== 1'b0) begin miscompares++; $display("FAIL ebreak_halt: got halted %b fault %b want 1/0", halted, fault); end
        vectors++; if (pc_out !== 64'h34) begin miscompares++; $display("FAIL ebreak_pc: got %h want 34", pc_out); end
        vectors++; if (st_cnt - s0 !== 5) begin miscompares++; $display("FAIL alu_store_count: got %0d want 5", st_cnt - s0); end
        vectors++; if (st_addr[s0] !== 64'h0 || st_data[s0] !== 64'd2) begin miscompares++; $display("FAIL add_x3: got @%h=%h want @0=2", st_addr[s0], st_data[s0]); end
        vectors++; if (st_data[s0+1] !== 64'hFFFF_FFFF_FFFF_FFF8) begin miscompares++; $display("FAIL sub_x4: got %h want fffffffffffffff8", st_data[s0+1]); end
        vectors++; if (st_data[s0+2] !== 64'd4) begin miscompares++; $display("FAIL and_x6: got %h want 4", st_data[s0+2]); end
        vectors++; if (st_data[s0+3] !== 64'd13) begin miscompares++; $display("FAIL or_x7: got %h want d", st_data[s0+3]); end
        vectors++; if (st_addr[s0+4] !== 64'd32 || st_data[s0+4] !== 64'd0) begin miscompares++; $display("FAIL x0_write: got @%h=%h want @20=0", st_addr[s0+4], st_data[s0+4]); end
    endtask

    task automatic test_load_wait();
        int cyc, s0, rts;
        enter_reset();
        imem[0] = ADDI(1, 0, 5);
        imem[1] = ADDI(2, 0, -3);
        imem[2] = RTYPE(7'b0000000, 3'b000, 3, 1, 2);
        imem[3] = STORE(3'b011, 3, 0, 8);
        imem[4] = LOAD(3'b011, 5, 0, 8);
        imem[5] = STORE(3'b011, 5, 0, 16);
        imem[6] = EBRK;
        dmem_wait = 3;
        s0 = st_cnt;
        release_reset();
        run_retires(4, 60, cyc);
        vectors++; if (cyc !== 19) begin miscompares++; $display("FAIL sd_wait_cycles: got %0d want 19", cyc); end
        rts = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            #1;
            if (retire) rts++;
            if (c >= 4 && c <= 7) begin
                vectors++;
                if (dmem_req !== 1'b1 || dmem_addr !== 64'h8 || dmem_we !== 1'b0) begin
                    miscompares++;
                    $display("FAIL ld_hold c%0d: got req %b addr %h we %b want 1/8/0", c, dmem_req, dmem_addr, dmem_we);
                end
            end
        end
        vectors++; if (retire !== 1'b1 || rts !== 1) begin miscompares++; $display("FAIL ld_8cycles: got retire %b count %0d want 1/1", retire, rts); end
        run_halt(60, cyc);
        vectors++; if (st_cnt - s0 !== 2) begin miscompares++; $display("FAIL ld_store_count: got %0d want 2", st_cnt - s0); end
        vectors++; if (st_addr[s0+1] !== 64'd16 || st_data[s0+1] !== 64'd2) begin miscompares++; $display("FAIL ld_x5: got @%h=%h want @10=2", st_addr[s0+1], st_data[s0+1]); end
    endtask

    task automatic test_branch(input logic [2:0] f3, input logic [63:0] exp_pc);
        int cyc;
        enter_reset();
        imem[0] = ADDI(1, 0, 5);
        imem[1] = ADDI(2, 0, -3);
        imem[2] = BR(3'b000, 1, 2, 100);
        imem[3] = BR(3'b001, 1, 2, 20);
        imem[6] = EBRK;
        imem[8] = BR(f3, 2, 1, -8);
        imem[9] = EBRK;
        dmem_wait = 0;
        release_reset();
        run_retires(5, 40, cyc);
        vectors++; if (cyc !== 17) begin miscompares++; $display("FAIL br_f3_%b_cycles: got %0d want 17", f3, cyc); end
        @(negedge clk);
        #1;
        vectors++; if (pc_out !== exp_pc || retire !== 1'b0) begin miscompares++; $display("FAIL br_f3_%b_pc: got %h retire %b want %h/0", f3, pc_out, retire, exp_pc); end
        run_halt(20, cyc);
        vectors++; if (halted !== 1'b1 || fault !== 1'b0 || pc_out !== exp_pc) begin miscompares++; $display("FAIL br_f3_%b_halt: got %b%b pc %h want 10 pc %h", f3, halted, fault, pc_out, exp_pc); end
    endtask

    task automatic test_faults();
        int cyc, d0;
        enter_reset();
        imem[0] = ADDI(1, 0, 4);
        imem[1] = LOAD(3'b011, 5, 1, 0);
        dmem_wait = 0;
        d0 = dreq_cycles;
        release_reset();
        run_halt(30, cyc);
        vectors++; if (halted !== 1'b1 || fault !== 1'b1) begin miscompares++; $display("FAIL misalign_fault: got %b%b want 11", halted, fault); end
        repeat (3) @(negedge clk);
        #1;
        vectors++; if (dreq_cycles !== d0 || imem_req !== 1'b0) begin miscompares++; $display("FAIL misalign_noreq: got dreq %0d imem_req %b want %0d/0", dreq_cycles, imem_req, d0); end
        vectors++; if (pc_out !== 64'h4 || halted !== 1'b1) begin miscompares++; $display("FAIL misalign_pc: got %h halted %b want 4/1", pc_out, halted); end
        enter_reset();
        imem[0] = ADDI(1, 0, 1);
        imem[1] = LOAD(3'b010, 5, 0, 0);
        release_reset();
        run_halt(30, cyc);
        vectors++; if (halted !== 1'b1 || fault !== 1'b1 || pc_out !== 64'h4) begin miscompares++; $display("FAIL illegal_op: got %b%b pc %h want 11 pc 4", halted, fault, pc_out); end
    endtask

    task automatic test_reset_mid_mem();
        int cyc, s0;
        enter_reset();
        imem[0] = ADDI(1, 0, 9);
        imem[1] = STORE(3'b011, 1, 0, 0);
        dmem_wait = 5;
        s0 = st_cnt;
        release_reset();
        run_retires(1, 20, cyc);
        for (int k = 0; k < 10 && !dmem_req; k++) begin
            @(negedge clk);
            #1;
        end
        vectors++; if (dmem_req !== 1'b1) begin miscompares++; $display("FAIL midmem_reach: got dmem_req %b want 1", dmem_req); end
        reset = 1'b1;
        #1;
        vectors++; if (dmem_req !== 1'b0 || imem_req !== 1'b0 || retire !== 1'b0) begin miscompares++; $display("FAIL midmem_drop: got %b%b%b want 000", dmem_req, imem_req, retire); end
        vectors++; if (pc_out !== 64'h0 || halted !== 1'b0) begin miscompares++; $display("FAIL midmem_pc: got %h halted %b want 0/0", pc_out, halted); end
        imem[0] = STORE(3'b011, 1, 0, 8);
        imem[1] = EBRK;
        dmem_wait = 0;
        release_reset();
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin miscompares++; $display("FAIL midmem_refetch: got %b %h want 1/0", imem_req, imem_addr); end
        run_halt(30, cyc);
        vectors++; if (st_cnt - s0 !== 1) begin miscompares++; $display("FAIL midmem_store_count: got %0d want 1", st_cnt - s0); end
        vectors++; if (st_addr[s0] !== 64'h8 || st_data[s0] !== 64'h0) begin miscompares++; $display("FAIL midmem_regs_cleared: got @%h=%h want @8=0", st_addr[s0], st_data[s0]); end
    endtask

    task automatic test_xlen32();
        int cyc;
        for (int i = 0; i < 64; i++) imem32[i] = 32'h0;
        imem32[0] = ADDI(1, 0, 5);
        imem32[1] = ADDI(2, 0, -3);
        imem32[2] = RTYPE(7'b0100000, 3'b000, 4, 2, 1);
        imem32[3] = STORE(3'b010, 4, 0, 4);
        imem32[4] = EBRK;
        @(negedge clk);
        rst32 = 1'b0;
        cyc = 0;
        while (!halted32 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        #1;
        vectors++; if (halted32 !== 1'b1 || fault32 !== 1'b0) begin miscompares++; $display("FAIL x32_halt: got %b%b want 10", halted32, fault32); end
        vectors++; if (st32_cnt !== 1 || st32_addr !== 32'h4) begin miscompares++; $display("FAIL x32_store: got count %0d addr %h want 1/4", st32_cnt, st32_addr); end
        vectors++; if (st32_data !== 32'hFFFF_FFF8) begin miscompares++; $display("FAIL x32_sub: got %h want fffffff8", st32_data); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_wait();
        test_branch(3'b100, 64'h18);
        test_branch(3'b101, 64'h24);
        test_faults();
        test_reset_mid_mem();
        test_xlen32();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
